alu_ctrl_decode: RTL and testbench

- Producer side of the ALU control interface.
- Takes a fetched RV32I instruction plus its PC and decodes the ALU operation (`ALU_* codes from ALUop.vh), the operand selects and the immediate.
- Holds the result in a registered ID/EX-style stage with a valid/ready handshake, flush and backpressure.
- Sits between fetch and execute; its outputs drive the ALU's ALUop/A/B muxing directly.

---
 rtl/alu_ctrl_decode_if.sv | 52 +++++
 rtl/alu_ctrl_decode.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_ctrl_decode.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_decode_if.sv
// ALU control interface: fetch-side inputs and decoded execute-side outputs.
// ALU_* operation codes follow the ALUop.vh encoding.
`ifndef ALU_XXX
`define ALU_ADD    4'd0
`define ALU_SUB    4'd1
`define ALU_SLL    4'd2
`define ALU_SLT    4'd3
`define ALU_SLTU   4'd4
`define ALU_XOR    4'd5
`define ALU_SRL    4'd6
`define ALU_SRA    4'd7
`define ALU_OR     4'd8
`define ALU_AND    4'd9
`define ALU_COPY_B 4'd10
`define ALU_XXX    4'd15
`endif

interface alu_ctrl_decode_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_op;
  logic            out_a_sel;
  logic            out_b_sel;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_reg_we;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_alu_op, out_a_sel,
    output out_b_sel, out_imm, out_rs1, out_rs2, out_rd,
    output out_reg_we, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_alu_op, out_a_sel,
    input  out_b_sel, out_imm, out_rs1, out_rs2, out_rd,
    input  out_reg_we, out_pc, out_illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// RV32I decode to ALU controls with a registered valid/ready stage.
// Optional ALU_CTRL_DECODE_SKID_EN adds a skid entry and a registered in_ready.
module alu_ctrl_decode #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst,
  alu_ctrl_decode_if.slave bus
);

  typedef struct packed {
    logic [3:0]      alu_op;
    logic            a_sel;
    logic            b_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_we;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  localparam entry_t RST_ENT = '{
    alu_op: `ALU_XXX,
    default: '0
  };

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_AUI  = 7'b0010111;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_BR   = 7'b1100011;

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  assign inst = bus.in_inst;
  assign opc  = inst[6:0];
  assign rd   = inst[11:7];
  assign f3   = inst[14:12];
  assign rs1  = inst[19:15];
  assign rs2  = inst[24:20];
  assign f7   = inst[31:25];

  function automatic logic [3:0] f3_op(
    input logic [2:0] fn,
    input logic       alt
  );
    logic [3:0] op;
    op = `ALU_XXX;
    case (fn)
      3'b000: op = alt ? `ALU_SUB : `ALU_ADD;
      3'b001: op = `ALU_SLL;
      3'b010: op = `ALU_SLT;
      3'b011: op = `ALU_SLTU;
      3'b100: op = `ALU_XOR;
      3'b101: op = alt ? `ALU_SRA : `ALU_SRL;
      3'b110: op = `ALU_OR;
      3'b111: op = `ALU_AND;
      default: op = `ALU_XXX;
    endcase
    return op;
  endfunction

  logic        is_r, is_i, is_lui, is_aui;
  logic        is_ld, is_st, is_jalr, is_jal, is_br;
  logic        ill;
  logic        we;
  logic        use1;
  logic        use2;
  logic [3:0]  op;
  logic signed [31:0] imm32;
  logic        sh;
  entry_t      dec;

  assign is_r    = opc == OPC_R;
  assign is_i    = opc == OPC_I;
  assign is_lui  = opc == OPC_LUI;
  assign is_aui  = opc == OPC_AUI;
  assign is_ld   = opc == OPC_LD;
  assign is_st   = opc == OPC_ST;
  assign is_jalr = opc == OPC_JALR;
  assign is_jal  = opc == OPC_JAL;
  assign is_br   = opc == OPC_BR;
  assign sh      = f3 == 3'b001 || f3 == 3'b101;

  always_comb begin
    dec   = '0;
    op    = `ALU_ADD;
    imm32 = '0;
    ill   = 1'b0;
    we    = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    unique case (1'b1)
      is_r: begin
        we   = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
        op   = f3_op(f3, f7[5]);
        ill  = !(f7 == 7'h00 ||
                 (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      is_i: begin
        we        = 1'b1;
        use1      = 1'b1;
        dec.b_sel = 1'b1;
        op        = f3_op(f3, f3 == 3'b101 && f7[5]);
        imm32     = {{20{inst[31]}}, inst[31:20]};
        // shifts carry only the shamt; upper imm bits select SRL/SRA
        if (sh) begin
          imm32 = {27'b0, inst[24:20]};
          ill   = !(f7 == 7'h00 || (f3 == 3'b101 && f7 == 7'h20));
        end
      end
      is_lui: begin
        we        = 1'b1;
        dec.b_sel = 1'b1;
        op        = `ALU_COPY_B;
        imm32     = {inst[31:12], 12'b0};
      end
      is_aui: begin
        we        = 1'b1;
        dec.a_sel = 1'b1;
        dec.b_sel = 1'b1;
        imm32     = {inst[31:12], 12'b0};
      end
      is_ld: begin
        we        = 1'b1;
        use1      = 1'b1;
        dec.b_sel = 1'b1;
        imm32     = {{20{inst[31]}}, inst[31:20]};
        ill       = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      is_st: begin
        use1      = 1'b1;
        use2      = 1'b1;
        dec.b_sel = 1'b1;
        imm32     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        ill       = f3[2] || f3 == 3'b011;
      end
      is_jalr: begin
        we        = 1'b1;
        use1      = 1'b1;
        dec.b_sel = 1'b1;
        imm32     = {{20{inst[31]}}, inst[31:20]};
        ill       = f3 != 3'b000;
      end
      is_jal: begin
        we        = 1'b1;
        dec.a_sel = 1'b1;
        dec.b_sel = 1'b1;
        imm32     = {{11{inst[31]}}, inst[31], inst[19:12],
                     inst[20], inst[30:21], 1'b0};
      end
      is_br: begin
        use1      = 1'b1;
        use2      = 1'b1;
        dec.a_sel = 1'b1;
        dec.b_sel = 1'b1;
        imm32     = {{19{inst[31]}}, inst[31], inst[7],
                     inst[30:25], inst[11:8], 1'b0};
        ill       = f3[2:1] == 2'b01;
      end
      default: ill = 1'b1;
    endcase
    dec.alu_op  = ill ? `ALU_XXX : op;
    dec.illegal = ill;
    dec.reg_we  = we && !ill && rd != 5'd0;
    dec.imm     = XLEN'(imm32);
    dec.rs1     = use1 ? rs1 : 5'd0;
    dec.rs2     = use2 ? rs2 : 5'd0;
    dec.rd      = rd;
    dec.pc      = bus.in_pc;
  end

  entry_t out_q;
  logic   out_v;

`ifdef ALU_CTRL_DECODE_SKID_EN
  entry_t skid_q;
  logic   skid_v;
  logic   acc;
  logic   free;

  assign bus.in_ready = !skid_v;
  assign acc  = bus.in_valid && !skid_v;
  assign free = !out_v || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= RST_ENT;
      out_v  <= 1'b0;
      skid_q <= RST_ENT;
      skid_v <= 1'b0;
    end else if (flush_i()) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (free) begin
      // skid holds the older entry, so it drains before new input
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= acc;
        if (acc) out_q <= dec;
      end
    end else if (acc) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end
`else
  assign bus.in_ready = !out_v || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= RST_ENT;
      out_v <= 1'b0;
    end else if (flush_i()) begin
      out_v <= 1'b0;
    end else if (bus.in_ready) begin
      out_v <= bus.in_valid;
      if (bus.in_valid) out_q <= dec;
    end
  end
`endif

  function automatic logic flush_i();
    return bus.flush;
  endfunction

  assign bus.out_valid   = out_v;
  assign bus.out_alu_op  = out_q.alu_op;
  assign bus.out_a_sel   = out_q.a_sel;
  assign bus.out_b_sel   = out_q.b_sel;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_reg_we  = out_q.reg_we;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Directed bench for alu_ctrl_decode: decode vectors, stall ordering, flush.
// Honours ALU_CTRL_DECODE_SKID_EN for the one stall-cycle in_ready value.
module tb_alu_ctrl_decode;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_SRA  = 4'd7;
  localparam logic [3:0] A_CPB  = 4'd10;
  localparam logic [3:0] A_XXX  = 4'd15;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_ctrl_decode_if #(.XLEN(32)) bus ();

  alu_ctrl_decode #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid  = 1'b1;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = 1'b1;
    step();
  endtask

  logic [31:0] items [6];
  logic [31:0] held;
  logic        hold_prev;
  logic        fin;
  logic        fout;
  int          idx;
  int          oidx;
  logic        rdy2;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_valid", bus.out_valid, 0);
    check("rst_op", bus.out_alu_op, A_XXX);
    check("rst_imm", bus.out_imm, 0);
    check("rst_pc", bus.out_pc, 0);
    check("rst_we", bus.out_reg_we, 0);
    check("rst_rdy", bus.in_ready, 1);

    send(32'h00500093, 32'h100);
    check("addi_valid", bus.out_valid, 1);
    check("addi_op", bus.out_alu_op, A_ADD);
    check("addi_asel", bus.out_a_sel, 0);
    check("addi_bsel", bus.out_b_sel, 1);
    check("addi_imm", bus.out_imm, 5);
    check("addi_rd", bus.out_rd, 1);
    check("addi_we", bus.out_reg_we, 1);
    check("addi_ill", bus.out_illegal, 0);
    check("addi_pc", bus.out_pc, 32'h100);

    send(32'h40208133, 32'h104);
    check("sub_op", bus.out_alu_op, A_SUB);
    check("sub_rs1", bus.out_rs1, 1);
    check("sub_rs2", bus.out_rs2, 2);
    check("sub_rd", bus.out_rd, 2);
    check("sub_asel", bus.out_a_sel, 0);
    check("sub_bsel", bus.out_b_sel, 0);
    check("sub_we", bus.out_reg_we, 1);

    send(32'h4030D093, 32'h108);
    check("srai_op", bus.out_alu_op, A_SRA);
    check("srai_sh", bus.out_imm[4:0], 3);
    check("srai_ill", bus.out_illegal, 0);

    send(32'h6030D093, 32'h10C);
    check("badsh_ill", bus.out_illegal, 1);
    check("badsh_op", bus.out_alu_op, A_XXX);
    check("badsh_we", bus.out_reg_we, 0);
    check("badsh_vld", bus.out_valid, 1);

    send(32'h12345237, 32'h110);
    check("lui_op", bus.out_alu_op, A_CPB);
    check("lui_imm", bus.out_imm, 32'h12345000);
    check("lui_rd", bus.out_rd, 4);
    check("lui_bsel", bus.out_b_sel, 1);

    send(32'h00100013, 32'h114);
    check("rd0_we", bus.out_reg_we, 0);

    send(32'hFFF00093, 32'h118);
    check("neg_imm", bus.out_imm, 32'hFFFFFFFF);

    send(32'h00001297, 32'h11C);
    check("aui_asel", bus.out_a_sel, 1);
    check("aui_op", bus.out_alu_op, A_ADD);
    check("aui_imm", bus.out_imm, 32'h1000);

    send(32'h008000EF, 32'h120);
    check("jal_imm", bus.out_imm, 8);
    check("jal_asel", bus.out_a_sel, 1);
    check("jal_we", bus.out_reg_we, 1);

    send(32'h0020A223, 32'h124);
    check("sw_imm", bus.out_imm, 4);
    check("sw_we", bus.out_reg_we, 0);
    check("sw_bsel", bus.out_b_sel, 1);

    send(32'h0000007F, 32'h128);
    check("badop_ill", bus.out_illegal, 1);
    check("badop_op", bus.out_alu_op, A_XXX);

    bus.in_valid = 1'b0;
    step();
    check("idle_vld", bus.out_valid, 0);

    for (int k = 1; k <= 6; k++)
      items[k-1] = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
`ifdef ALU_CTRL_DECODE_SKID_EN
    rdy2 = 1'b1;
`else
    rdy2 = 1'b0;
`endif
    idx       = 0;
    oidx      = 0;
    hold_prev = 1'b0;
    held      = '0;
    for (int c = 0; c < 40 && oidx < 6; c++) begin
      bus.in_valid  = idx < 6;
      bus.in_inst   = idx < 6 ? items[idx] : 32'h0;
      bus.out_ready = !(c >= 2 && c <= 4);
      #3;
      if (c == 2) check("stall_rdy_c2", bus.in_ready, rdy2);
      if (c == 3 || c == 4) check("stall_rdy", bus.in_ready, 0);
      if (hold_prev) check("hold_imm", bus.out_imm, held);
      hold_prev = bus.out_valid && !bus.out_ready;
      held      = bus.out_imm;
      fin  = bus.in_valid && bus.in_ready;
      fout = bus.out_valid && bus.out_ready;
      if (fout) begin
        check("order_imm", bus.out_imm, oidx + 1);
        check("order_rd", bus.out_rd, oidx + 1);
        oidx++;
      end
      step();
      if (fin) idx++;
    end
    check("drained", oidx, 6);
    bus.in_valid = 1'b0;
    check("no_dup0", bus.out_valid, 0);
    step();
    check("no_dup1", bus.out_valid, 0);

    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h00700093;
    bus.out_ready = 1'b0;
    step();
    check("fl_pre", bus.out_valid, 1);
    check("fl_pre_imm", bus.out_imm, 7);
    bus.in_inst = 32'h00800093;
    bus.flush   = 1'b1;
    step();
    check("fl_vld", bus.out_valid, 0);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_gone", bus.out_valid, 0);
    end
    check("fl_rdy", bus.in_ready, 1);
    send(32'h00900093, 32'h200);
    check("fl_after", bus.out_valid, 1);
    check("fl_after_imm", bus.out_imm, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
